matrix_reader: RTL and testbench

MATRIX_READER -- requirements
Module: matrix_reader

---
 rtl/matrix_reader.sv | 166 ++++++++++++++++
 tb/tb_matrix_reader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_reader.sv
// matrix_reader: ROW x COL element store streamed out in row- or column-major
// order over a valid/ready port; the array can be written in any state.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   wr_en, wr_row, wr_col, wr_data element write (out-of-range ignored)
//   start, transpose               stream request and order (0 row, 1 col)
//   busy                           stream in progress
//   out_valid, out_ready           output handshake
//   out_data, out_row, out_col     presented element and its indices
//   out_last                       presented element is [ROW-1][COL-1]
module matrix_reader #(
    parameter int ROW   = 5,
    parameter int COL   = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [7:0]       wr_row,
    input  logic [7:0]       wr_col,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             start,
    input  logic             transpose,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [7:0]       out_row,
    output logic [7:0]       out_col,
    output logic             out_last
);

    localparam int RW = (ROW > 1) ? $clog2(ROW) : 1;
    localparam int CW = (COL > 1) ? $clog2(COL) : 1;

    localparam logic [8:0] ROW_N   = 9'(ROW);
    localparam logic [8:0] COL_N   = 9'(COL);
    localparam logic [7:0] ROW_MAX = 8'(ROW - 1);
    localparam logic [7:0] COL_MAX = 8'(COL - 1);
    localparam logic       ONE_EL  = (ROW == 1) && (COL == 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mem_q [ROW][COL];
    logic [WIDTH-1:0] data_q, data_d;
    logic [7:0]       row_q, row_d;
    logic [7:0]       col_q, col_d;
    logic             last_q, last_d;
    logic             tr_q, tr_d;

    logic             wr_ok;
    logic             row_end, col_end;
    logic [7:0]       nxt_row, nxt_col;
    logic             nxt_last;
    logic [7:0]       rd_row, rd_col;
    logic [WIDTH-1:0] rd_data;

    // ------------------------------------------------------------
    // Element store: not reset, so contents survive rst_n.
    // ------------------------------------------------------------
    assign wr_ok = wr_en
                 && ({1'b0, wr_row} < ROW_N)
                 && ({1'b0, wr_col} < COL_N);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[RW'(wr_row)][CW'(wr_col)] <= wr_data;
        end
    end

    // ------------------------------------------------------------
    // Next position in the selected traversal order.
    // ------------------------------------------------------------
    assign row_end = (row_q == ROW_MAX);
    assign col_end = (col_q == COL_MAX);

    always_comb begin
        nxt_row = row_q;
        nxt_col = col_q;
        if (tr_q) begin
            nxt_row = row_end ? 8'd0 : row_q + 8'd1;
            nxt_col = row_end ? col_q + 8'd1 : col_q;
        end else begin
            nxt_col = col_end ? 8'd0 : col_q + 8'd1;
            nxt_row = col_end ? row_q + 8'd1 : row_q;
        end
    end

    assign nxt_last = (nxt_row == ROW_MAX) && (nxt_col == COL_MAX);

    // Read port: origin when launching, else the next position. The read
    // sees the pre-edge array, so a same-edge write is not forwarded.
    assign rd_row  = (state_q == STREAM) ? nxt_row : 8'd0;
    assign rd_col  = (state_q == STREAM) ? nxt_col : 8'd0;
    assign rd_data = mem_q[RW'(rd_row)][CW'(rd_col)];

    // ------------------------------------------------------------
    // Stream FSM
    // ------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        row_d   = row_q;
        col_d   = col_q;
        last_d  = last_q;
        tr_d    = tr_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                    tr_d    = transpose;
                    row_d   = 8'd0;
                    col_d   = 8'd0;
                    data_d  = rd_data;
                    last_d  = ONE_EL;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (last_q) begin
                        // Indices and data stay on the final element.
                        state_d = IDLE;
                        last_d  = 1'b0;
                    end else begin
                        row_d  = nxt_row;
                        col_d  = nxt_col;
                        data_d = rd_data;
                        last_d = nxt_last;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            row_q   <= 8'd0;
            col_q   <= 8'd0;
            last_q  <= 1'b0;
            tr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            row_q   <= row_d;
            col_q   <= col_d;
            last_q  <= last_d;
            tr_q    <= tr_d;
        end
    end

    assign busy      = (state_q == STREAM);
    assign out_valid = (state_q == STREAM);
    assign out_data  = data_q;
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_matrix_reader.sv
// tb_matrix_reader: randomized and directed stimulus for matrix_reader,
// checked every cycle against a position-counting reference model.
module tb_matrix_reader;

    localparam int ROW = 5;
    localparam int COL = 4;
    localparam int N   = ROW * COL;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [7:0]  wr_row;
    logic [7:0]  wr_col;
    logic [15:0] wr_data;
    logic        start;
    logic        transpose;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [7:0]  out_row;
    logic [7:0]  out_col;
    logic        out_last;

    int n_cmp;
    int n_bad;

    matrix_reader #(.ROW(ROW), .COL(COL), .WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_row   (wr_row),
        .wr_col   (wr_col),
        .wr_data  (wr_data),
        .start    (start),
        .transpose(transpose),
        .busy     (busy),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_row  (out_row),
        .out_col  (out_col),
        .out_last (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: stream position k, order, and a shadow array.
    function automatic int prow(input int k, input bit tr);
        return tr ? (k % ROW) : (k / COL);
    endfunction

    function automatic int pcol(input int k, input bit tr);
        return tr ? (k / ROW) : (k % COL);
    endfunction

    logic [15:0] mm [ROW][COL];
    bit          m_valid;
    bit          m_tr;
    int          m_k;
    logic [15:0] m_data;
    logic [7:0]  m_row;
    logic [7:0]  m_col;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_tr    <= 1'b0;
            m_k     <= 0;
            m_data  <= '0;
            m_row   <= '0;
            m_col   <= '0;
        end else begin
            if (wr_en && wr_row < ROW && wr_col < COL)
                mm[wr_row][wr_col] <= wr_data;
            if (!m_valid) begin
                if (start) begin
                    m_valid <= 1'b1;
                    m_tr    <= transpose;
                    m_k     <= 0;
                    m_row   <= '0;
                    m_col   <= '0;
                    m_data  <= mm[0][0];
                end
            end else if (out_ready) begin
                if (m_k == N - 1) begin
                    m_valid <= 1'b0;
                end else begin
                    m_k    <= m_k + 1;
                    m_row  <= 8'(prow(m_k + 1, m_tr));
                    m_col  <= 8'(pcol(m_k + 1, m_tr));
                    m_data <= mm[prow(m_k + 1, m_tr)][pcol(m_k + 1, m_tr)];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("outputs",
                  {out_valid, busy, out_last, out_row, out_col, out_data},
                  {m_valid, m_valid, (m_valid && m_k == N - 1),
                   m_row, m_col, m_data});
        end
    end

    logic [15:0] got[$];
    bit          lastf[$];
    int          busy_cyc;
    int          hold12;

    task automatic wr(input int r, input int c, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_row  = 8'(r);
        wr_col  = 8'(c);
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
    endtask

    task automatic run(input bit tr, input int stall_idx, input int stall_n,
                       input bit rnd, input int start_idx, input int rst_idx,
                       input int wr_idx);
        int  stalled;
        bit  done;
        bit  st_done;
        bit  wr_done;
        got.delete();
        lastf.delete();
        busy_cyc = 0;
        hold12   = 0;
        stalled  = 0;
        done     = 1'b0;
        st_done  = 1'b0;
        wr_done  = 1'b0;
        start     = 1'b1;
        transpose = tr;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        transpose = 1'($urandom);
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            wr_en     = 1'b0;
            out_ready = 1'b1;
            if (rnd)
                out_ready = ($urandom_range(0, 3) != 0);
            if (got.size() == stall_idx && stalled < stall_n) begin
                out_ready = 1'b0;
                stalled++;
            end
            if (got.size() == start_idx && !st_done) begin
                start   = 1'b1;
                st_done = 1'b1;
            end
            if (rnd && $urandom_range(0, 2) == 0) begin
                wr_en   = 1'b1;
                wr_row  = 8'($urandom_range(0, ROW + 1));
                wr_col  = 8'($urandom_range(0, COL + 1));
                wr_data = 16'($urandom);
            end
            if (got.size() == wr_idx && !wr_done) begin
                wr_en   = 1'b1;
                wr_row  = 8'd4;
                wr_col  = 8'd3;
                wr_data = 16'hBEEF;
                wr_done = 1'b1;
            end
            if (got.size() == rst_idx) begin
                start = 1'b0;
                wr_en = 1'b0;
                #3 rst_n = 1'b0;
                #1;
                check("async_reset",
                      {out_valid, busy, out_last, out_data}, 64'd0);
                @(posedge clk);
                #1;
                check("reset_hold",
                      {out_valid, busy, out_row, out_col}, 64'd0);
                rst_n = 1'b1;
                done  = 1'b1;
            end else begin
                @(negedge clk);
                if (busy)
                    busy_cyc++;
                if (out_valid && out_data == 16'h0012)
                    hold12++;
                if (out_valid && out_ready) begin
                    got.push_back(out_data);
                    lastf.push_back(out_last);
                end
                done = !busy;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
        wr_en = 1'b0;
        check("stream_done", 64'(done), 64'd1);
    endtask

    // Expected values for the preloaded pattern, 0x0RC.
    function automatic logic [15:0] pat(input bit tr, input int k);
        return 16'((prow(k, tr) << 4) | pcol(k, tr));
    endfunction

    task automatic std_check(input string nm, input bit tr);
        check({nm, "_count"}, 64'(got.size()), 64'(N));
        if (got.size() == N) begin
            for (int k = 0; k < N; k++) begin
                check({nm, "_elem"}, 64'(got[k]), 64'(pat(tr, k)));
                check({nm, "_last"}, 64'(lastf[k]), 64'(k == N - 1));
            end
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_row    = '0;
        wr_col    = '0;
        wr_data   = '0;
        start     = 1'b0;
        transpose = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state",
              {out_valid, busy, out_last, out_row, out_col, out_data}, 64'd0);
        rst_n = 1'b1;

        for (int r = 0; r < ROW; r++)
            for (int c = 0; c < COL; c++)
                wr(r, c, 16'((r << 4) | c));
        wr(5, 0, 16'hFFFF);
        wr(0, 4, 16'hFFFF);
        wr(255, 255, 16'hFFFF);

        run(1'b0, -1, 0, 1'b0, -1, -1, -1);
        std_check("row_major", 1'b0);
        check("row_major_first", 64'(got[0]), 64'h0000);
        check("row_major_5th", 64'(got[4]), 64'h0010);
        check("row_major_final", 64'(got[N-1]), 64'h0043);
        check("throughput", 64'(busy_cyc), 64'(N));
        check("idle_after", 64'(busy), 64'd0);

        run(1'b1, -1, 0, 1'b0, -1, -1, -1);
        std_check("col_major", 1'b1);
        check("col_major_2nd", 64'(got[1]), 64'h0010);
        check("col_major_6th", 64'(got[5]), 64'h0001);

        run(1'b0, 6, 3, 1'b0, -1, -1, -1);
        std_check("backpressure", 1'b0);
        check("hold_0012", 64'(hold12), 64'd4);
        check("busy_stall", 64'(busy_cyc), 64'(N + 3));

        run(1'b0, -1, 0, 1'b0, 4, -1, -1);
        std_check("start_busy", 1'b0);
        repeat (3) @(negedge clk);
        check("no_restart", {out_valid, busy}, 64'd0);
        @(posedge clk);
        #1;

        run(1'b0, -1, 0, 1'b0, -1, 7, -1);
        check("reset_got", 64'(got.size()), 64'd7);
        run(1'b0, -1, 0, 1'b0, -1, -1, -1);
        std_check("restart", 1'b0);

        run(1'b0, -1, 0, 1'b0, -1, -1, 4);
        check("beef_count", 64'(got.size()), 64'(N));
        if (got.size() == N) begin
            check("beef_final", 64'(got[N-1]), 64'hBEEF);
            check("beef_4th", 64'(got[3]), 64'h0003);
        end
        wr(4, 3, 16'h0043);

        repeat (8) begin
            run(1'($urandom), -1, 0, 1'b1, -1, -1, -1);
            check("rand_count", 64'(got.size()), 64'(N));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
